// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings for the two-port SDRAM arbiter: FSM states, grant one-hots, default widths.
package sdram_arbiter_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_A   = 2'd1,
        GNT_B   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            GNT_A:   grant_of = GRANT_A;
            GNT_B:   grant_of = GRANT_B;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sdram_arb_timer.sv
// Grant-age counter: cleared to zero while clear is high, counts up while en, saturates.
// tc is high during the TC-th counted cycle, i.e. the last cycle a grant may still wait.
module sdram_arb_timer #(
    parameter int TC = 255,
    parameter int W  = $clog2(TC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TC - 1));

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM controller port between CPU port A (rd/wr) and video port B (rd).
// Grant 1 cycle after request; acks forwarded combinationally; RELEASE+IDLE between grants.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_B_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data_out,
    output logic [DATA_W-1:0] a_data_in,
    input  logic              a_req,
    input  logic              a_write,
    output logic              a_ready,
    output logic              a_done,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_req,
    output logic [DATA_W-1:0] b_data_in,
    output logic              b_ready,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_data_out,
    input  logic [DATA_W-1:0] sdram_data_in,
    output logic              sdram_req,
    output logic              sdram_write,
    input  logic              sdram_ready,
    input  logic              sdram_done,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int SW = $clog2(MAX_B_BURST + 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] b_streak, b_streak_nxt;
    logic          a_any, in_grant, ack, withdraw, tmr_tc, tmo;

    assign a_any    = a_req | a_write;
    assign in_grant = (state == GNT_A) || (state == GNT_B);

    always_comb begin
        sdram_req   = 1'b0;
        sdram_write = 1'b0;
        sdram_addr  = a_addr;
        case (state)
            GNT_A: begin
                sdram_write = a_write;
                sdram_req   = a_req & ~a_write;
            end
            GNT_B: begin
                sdram_req  = b_req;
                sdram_addr = b_addr;
            end
            default: ;
        endcase
    end

    assign sdram_data_out = a_data_out;
    assign a_data_in      = sdram_data_in;
    assign b_data_in      = sdram_data_in;

    assign a_ready = (state == GNT_A) & sdram_req & sdram_ready;
    assign a_done  = (state == GNT_A) & sdram_write & sdram_done;
    assign b_ready = (state == GNT_B) & sdram_req & sdram_ready;
    assign ack     = a_ready | a_done | b_ready;

    // A dropped request ends the grant without waiting for the controller.
    assign withdraw = ((state == GNT_A) & ~a_any) | ((state == GNT_B) & ~b_req);
    assign tmo      = in_grant & tmr_tc & ~ack & ~withdraw;

    sdram_arb_timer #(
        .TC (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (~in_grant),
        .en    (in_grant),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_nxt    = state;
        b_streak_nxt = b_streak;
        case (state)
            IDLE: begin
                if (!a_any) begin
                    b_streak_nxt = '0;
                end
                // B may only starve A for MAX_B_BURST consecutive grants.
                if (b_req && ((b_streak < SW'(MAX_B_BURST)) || !a_any)) begin
                    state_nxt = GNT_B;
                    if (a_any) begin
                        b_streak_nxt = b_streak + 1'b1;
                    end
                end else if (a_any) begin
                    state_nxt    = GNT_A;
                    b_streak_nxt = '0;
                end
            end
            GNT_A, GNT_B: begin
                if (ack || withdraw || tmr_tc) begin
                    state_nxt = RELEASE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            b_streak    <= '0;
            grant       <= GRANT_NONE;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            b_streak    <= b_streak_nxt;
            grant       <= grant_of(state_nxt);
            timeout_err <= tmo;
        end
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single top-level SDRAM controller port between two requesters.
- Port A is the CPU xbus RAM path: read or write, level request held until ack.
- Port B is the video fetch path: read-only, level request held until ack.
- Sits between the xbus RAM decoder / video fetch unit and the SDRAM controller. Provides fair arbitration, bounded video priority and a lost-ack timeout.

Parameters:
- ADDR_W, 22, address width in words.
- DATA_W, 32, data width.
- MAX_B_BURST, 4, consecutive B grants allowed while A is waiting.
- TIMEOUT, 255, cycles a grant may wait for ready/done before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- a_addr  in  ADDR_W  port A address.
- a_data_out  in  DATA_W  port A write data.
- a_data_in  out  DATA_W  port A read data.
- a_req  in  1  port A read request (level).
- a_write  in  1  port A write request (level).
- a_ready  out  1  port A read ack pulse.
- a_done  out  1  port A write ack pulse.
- b_addr  in  ADDR_W  port B address.
- b_req  in  1  port B read request (level).
- b_data_in  out  DATA_W  port B read data.
- b_ready  out  1  port B read ack pulse.
- sdram_addr  out  ADDR_W  controller address.
- sdram_data_out  out  DATA_W  controller write data.
- sdram_data_in  in  DATA_W  controller read data.
- sdram_req  out  1  controller read request.
- sdram_write  out  1  controller write request.
- sdram_ready  in  1  controller read-complete pulse.
- sdram_done  in  1  controller write-complete pulse.
- grant  out  2  one-hot {B,A} current owner.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; grant=0; b_streak=0; tmr=0.
  - sdram_req, sdram_write, a_ready, a_done, b_ready and timeout_err all 0.
- States: IDLE, GNT_A, GNT_B, RELEASE.
- IDLE:
  - If b_req and (b_streak<MAX_B_BURST or no A request): go to GNT_B and increment b_streak (saturating).
  - Else if a_req|a_write: go to GNT_A and clear b_streak.
  - Else stay. b_streak clears whenever IDLE sees no A request.
- GNT_A:
  - sdram_write = a_write.
  - sdram_req = a_req & ~a_write. Write has precedence if both are asserted.
  - sdram_addr and sdram_data_out are taken from A.
- GNT_B:
  - sdram_req = b_req; sdram_write = 0; sdram_addr = b_addr.
- Outside a grant, sdram_req and sdram_write are 0. sdram_addr and sdram_data_out hold A's values.
- Ack forwarding is combinational, in the same cycle:
  - a_ready = GNT_A & sdram_req & sdram_ready.
  - a_done = GNT_A & sdram_write & sdram_done.
  - b_ready = GNT_B & sdram_req & sdram_ready.
  - Acks arriving in any other state are discarded.
- a_data_in and b_data_in are wired directly to sdram_data_in.
- Grant exit:
  - On a forwarded ack, go to RELEASE.
  - RELEASE lasts one cycle with all requests low, then goes to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 gives grant and sdram_req at cycle 1.
  - Ack at cycle n gives RELEASE at n+1, IDLE at n+2, and the earliest next grant at n+3.
- Requester withdraws its request before ack: go to RELEASE next cycle; no ack is forwarded.
- Timeout:
  - tmr counts cycles in GNT_A or GNT_B and clears on entry.
  - When tmr reaches TIMEOUT with no ack: pulse timeout_err, go to RELEASE, forward no ack.
  - The requester retries because its level is still high.
- grant is registered and matches the state: 01 = GNT_A, 10 = GNT_B, 00 otherwise.
- Reset asserted mid-grant drops all outputs immediately (async).

Decomposition:
- Shared package:
  - State encoding constants (IDLE, GNT_A, GNT_B, RELEASE).
  - Grant one-hot constants (GRANT_NONE, GRANT_A, GRANT_B).
  - Default ADDR_W and DATA_W.
- One natural sub-module, sdram_arb_timer: a loadable up-counter with a terminal-count flag, used for the timeout.
- Arbitration, muxing and the FSM stay in sdram_arbiter.

Test Plan:
- A read alone:
  - Stimulus: a_req=1, a_addr=22'o1234; sdram_ready pulses 3 cycles after grant with data 32'hDEADBEEF.
  - Required: sdram_req rises 1 cycle after a_req; a_ready pulses in the same cycle as sdram_ready; a_data_in=DEADBEEF; grant goes 01 then 00.
- A write:
  - Stimulus: a_write=1, a_data_out=32'h12345678, a_addr=22'o777; sdram_done pulses.
  - Required: sdram_write=1, sdram_req=0, sdram_data_out=12345678, a_done pulses once.
- Contention:
  - Stimulus: a_req and b_req held high continuously; controller acks each grant after 2 cycles.
  - Required grant sequence: B,B,B,B,A,B,B,B,B,A…, with MAX_B_BURST=4 and RELEASE between every grant.
- Timeout:
  - Stimulus: b_req=1 with no sdram_ready.
  - Required: timeout_err pulses exactly 255 cycles after the grant; no b_ready; B is re-granted 2 cycles later.
- Withdraw:
  - Stimulus: a_req drops 1 cycle into GNT_A, and sdram_ready pulses one cycle later.
  - Required: a_ready stays 0; state goes RELEASE then IDLE.
- Async reset:
  - Stimulus: assert reset (low) mid-GNT_B, between clock edges.
  - Required: sdram_req=0 and grant=00 immediately; after release, a fresh request is granted normally.
